// File: rtl/cond_logic.sv
`default_nettype none
// ============================================================================
// Module   : cond_logic
// Purpose  : Condition-code unit at the consumer end of the ALU flag
//            interface. Holds the architectural NZCV flag register, checks
//            each instruction's condition field against the stored flags,
//            gates the PC, register-file and memory write enables, and keeps
//            saturating debug counters of executed and skipped instructions.
// Ports    : clk, reset         - rising-edge clock, sync active-high reset
//            instr_valid        - decoded instruction present this cycle
//            stall              - freezes all state (wins over flush)
//            flush              - discards the current instruction
//            cond[3:0]          - instruction condition field
//            alu_flags[3:0]     - {V,C,N,Z} produced for this instruction
//            flag_w[1:0]        - [1] writes N,Z ; [0] writes C,V
//            pc_s/reg_w/mem_w   - decoder write requests
//            no_write           - compare-type, suppress register write
//            pc_src/reg_write/mem_write/cond_ex - registered gated enables
//            flags[3:0]         - architectural flags {V,C,N,Z}
//            exec_cnt/skip_cnt  - saturating instruction counters
// Revision : 1.0 - initial release
// ============================================================================
module cond_logic #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       cond,
  input  logic [3:0]       alu_flags,
  input  logic [1:0]       flag_w,
  input  logic             pc_s,
  input  logic             reg_w,
  input  logic             mem_w,
  input  logic             no_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_write,
  output logic             cond_ex,
  output logic [3:0]       flags,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] skip_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Stored flag aliases; the check never looks at alu_flags so an
  // instruction cannot observe its own results.
  logic w_v, w_c, w_n, w_z;
  logic w_pass;
  logic w_accept;

  assign w_v = flags[3];
  assign w_c = flags[2];
  assign w_n = flags[1];
  assign w_z = flags[0];

  assign w_accept = instr_valid & ~stall & ~flush;

  always_comb begin
    w_pass = 1'b0;
    case (cond)
      4'b0000: w_pass = w_z;
      4'b0001: w_pass = ~w_z;
      4'b0010: w_pass = w_c;
      4'b0011: w_pass = ~w_c;
      4'b0100: w_pass = w_n;
      4'b0101: w_pass = ~w_n;
      4'b0110: w_pass = w_v;
      4'b0111: w_pass = ~w_v;
      4'b1000: w_pass = w_c & ~w_z;
      4'b1001: w_pass = ~w_c | w_z;
      4'b1010: w_pass = (w_n == w_v);
      4'b1011: w_pass = (w_n != w_v);
      4'b1100: w_pass = ~w_z & (w_n == w_v);
      4'b1101: w_pass = w_z | (w_n != w_v);
      4'b1110: w_pass = 1'b1;
      default: w_pass = 1'b0;  // 1111 reserved: counts as skipped
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags     <= 4'b0000;
      pc_src    <= 1'b0;
      reg_write <= 1'b0;
      mem_write <= 1'b0;
      cond_ex   <= 1'b0;
      exec_cnt  <= '0;
      skip_cnt  <= '0;
    end else if (!stall) begin
      // Enables are one-cycle pulses: cleared unless an accepted
      // instruction re-asserts them below (covers idle and flush cycles).
      pc_src    <= 1'b0;
      reg_write <= 1'b0;
      mem_write <= 1'b0;
      cond_ex   <= 1'b0;
      if (w_accept) begin
        cond_ex   <= w_pass;
        pc_src    <= w_pass & pc_s;
        reg_write <= w_pass & reg_w & ~no_write;
        mem_write <= w_pass & mem_w;
        if (w_pass) begin
          if (flag_w[1]) flags[1:0] <= alu_flags[1:0];
          if (flag_w[0]) flags[3:2] <= alu_flags[3:2];
          if (exec_cnt != C_CNT_MAX) exec_cnt <= exec_cnt + C_CNT_ONE;
        end else begin
          if (skip_cnt != C_CNT_MAX) skip_cnt <= skip_cnt + C_CNT_ONE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cond_logic.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_logic
// Purpose  : Directed self-checking bench for cond_logic. A narrow counter
//            width keeps saturation reachable in a few cycles.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cond_logic;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             instr_valid;
  logic             stall;
  logic             flush;
  logic [3:0]       cond;
  logic [3:0]       alu_flags;
  logic [1:0]       flag_w;
  logic             pc_s;
  logic             reg_w;
  logic             mem_w;
  logic             no_write;
  logic             pc_src;
  logic             reg_write;
  logic             mem_write;
  logic             cond_ex;
  logic [3:0]       flags;
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] skip_cnt;

  int checks = 0;
  int errors = 0;

  cond_logic #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .stall       (stall),
    .flush       (flush),
    .cond        (cond),
    .alu_flags   (alu_flags),
    .flag_w      (flag_w),
    .pc_s        (pc_s),
    .reg_w       (reg_w),
    .mem_w       (mem_w),
    .no_write    (no_write),
    .pc_src      (pc_src),
    .reg_write   (reg_write),
    .mem_write   (mem_write),
    .cond_ex     (cond_ex),
    .flags       (flags),
    .exec_cnt    (exec_cnt),
    .skip_cnt    (skip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    cond = 4'b0000; alu_flags = 4'b0000; flag_w = 2'b00;
    pc_s = 1'b0; reg_w = 1'b0; mem_w = 1'b0; no_write = 1'b0;
  endtask

  task automatic instr(input logic [3:0] c, input logic [1:0] fw,
                       input logic [3:0] af, input logic p, input logic r,
                       input logic m, input logic nw);
    instr_valid = 1'b1; stall = 1'b0; flush = 1'b0;
    cond = c; flag_w = fw; alu_flags = af;
    pc_s = p; reg_w = r; mem_w = m; no_write = nw;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", flags); end
    checks++; if ({pc_src, reg_write, mem_write, cond_ex} !== 4'b0000) begin errors++; $display("FAIL reset_enables got %b exp 0000", {pc_src, reg_write, mem_write, cond_ex}); end
    checks++; if (exec_cnt !== 4'd0 || skip_cnt !== 4'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", exec_cnt, skip_cnt); end
    // EQ against Z=0 fails
    instr(4'b0000, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checks++; if (reg_write !== 1'b0 || cond_ex !== 1'b0) begin errors++; $display("FAIL reset_eq_skip reg_write=%b cond_ex=%b exp 0 0", reg_write, cond_ex); end
    checks++; if (skip_cnt !== 4'd1 || exec_cnt !== 4'd0) begin errors++; $display("FAIL reset_eq_cnt got %0d/%0d exp exec 0 skip 1", exec_cnt, skip_cnt); end
    idle();
  endtask

  task automatic test_flag_write();
    instr(4'b1110, 2'b11, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++; if (flags !== 4'b0001 || cond_ex !== 1'b1) begin errors++; $display("FAIL fw_set flags=%b cond_ex=%b exp 0001 1", flags, cond_ex); end
    instr(4'b0000, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL fw_eq_pass reg_write=%b exp 1", reg_write); end
    checks++; if (exec_cnt !== 4'd2) begin errors++; $display("FAIL fw_exec_cnt got %0d exp 2", exec_cnt); end
    idle();
  endtask

  task automatic test_partial_write();
    instr(4'b1110, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);   // exec 3
    tick();
    checks++; if (flags !== 4'b1111) begin errors++; $display("FAIL pw_all flags=%b exp 1111", flags); end
    instr(4'b1110, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);   // exec 4
    tick();
    checks++; if (flags !== 4'b1100) begin errors++; $display("FAIL pw_nz flags=%b exp 1100", flags); end
    instr(4'b1110, 2'b01, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);   // exec 5
    tick();
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL pw_cv flags=%b exp 0100", flags); end
    // CC with C=1 fails: request must be ignored
    instr(4'b0011, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);   // skip 2
    tick();
    checks++; if (flags !== 4'b0100 || cond_ex !== 1'b0) begin errors++; $display("FAIL pw_fail_hold flags=%b cond_ex=%b exp 0100 0", flags, cond_ex); end
    checks++; if (exec_cnt !== 4'd5 || skip_cnt !== 4'd2) begin errors++; $display("FAIL pw_cnt got %0d/%0d exp 5/2", exec_cnt, skip_cnt); end
    idle();
  endtask

  task automatic test_signed();
    instr(4'b1110, 2'b11, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);   // N=1 V=0 C=0 Z=0, exec 6
    tick();
    checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL sg_setup flags=%b exp 0010", flags); end
    instr(4'b1011, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);   // LT pass, exec 7
    tick();
    checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL sg_lt cond_ex=%b exp 1", cond_ex); end
    instr(4'b1010, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);   // GE skip, skip 3
    tick();
    checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL sg_ge cond_ex=%b exp 0", cond_ex); end
    instr(4'b1100, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);   // GT skip, skip 4
    tick();
    checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL sg_gt cond_ex=%b exp 0", cond_ex); end
    instr(4'b1101, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);   // LE pass, exec 8
    tick();
    checks++; if (cond_ex !== 1'b1) begin errors++; $display("FAIL sg_le cond_ex=%b exp 1", cond_ex); end
    instr(4'b1000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);   // HI with C=0 skip, skip 5
    tick();
    checks++; if (cond_ex !== 1'b0) begin errors++; $display("FAIL sg_hi cond_ex=%b exp 0", cond_ex); end
    checks++; if (exec_cnt !== 4'd8 || skip_cnt !== 4'd5) begin errors++; $display("FAIL sg_cnt got %0d/%0d exp 8/5", exec_cnt, skip_cnt); end
    idle();
  endtask

  task automatic test_back_to_back();
    // flags 0010 (Z=0): EQ must not see its own alu Z=1
    instr(4'b0000, 2'b11, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);   // skip 6
    tick();
    checks++; if (cond_ex !== 1'b0 || flags !== 4'b0010) begin errors++; $display("FAIL b2b_own cond_ex=%b flags=%b exp 0 0010", cond_ex, flags); end
    instr(4'b1110, 2'b11, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);   // exec 9
    tick();
    checks++; if (flags !== 4'b0001) begin errors++; $display("FAIL b2b_set flags=%b exp 0001", flags); end
    instr(4'b0000, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);   // exec 10
    tick();
    checks++; if (reg_write !== 1'b1 || cond_ex !== 1'b1) begin errors++; $display("FAIL b2b_use reg_write=%b cond_ex=%b exp 1 1", reg_write, cond_ex); end
    idle();
  endtask

  task automatic test_gating();
    instr(4'b1110, 2'b00, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1);   // exec 11
    tick();
    checks++; if ({pc_src, reg_write, mem_write, cond_ex} !== 4'b1011) begin errors++; $display("FAIL gate_nowrite got %b exp 1011", {pc_src, reg_write, mem_write, cond_ex}); end
    instr(4'b1111, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0);   // skip 7
    tick();
    checks++; if ({pc_src, reg_write, mem_write, cond_ex} !== 4'b0000) begin errors++; $display("FAIL gate_nv got %b exp 0000", {pc_src, reg_write, mem_write, cond_ex}); end
    checks++; if (skip_cnt !== 4'd7 || flags !== 4'b0001) begin errors++; $display("FAIL gate_nv_state skip=%0d flags=%b exp 7 0001", skip_cnt, flags); end
    instr(4'b1110, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);   // exec 12
    tick();
    checks++; if ({pc_src, reg_write, mem_write, cond_ex} !== 4'b0101) begin errors++; $display("FAIL gate_reg got %b exp 0101", {pc_src, reg_write, mem_write, cond_ex}); end
    idle();
    tick();
    checks++; if ({pc_src, reg_write, mem_write, cond_ex} !== 4'b0000) begin errors++; $display("FAIL gate_pulse got %b exp 0000", {pc_src, reg_write, mem_write, cond_ex}); end
  endtask

  task automatic test_stall_flush();
    instr(4'b1110, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);   // exec 13
    tick();
    instr(4'b1110, 2'b11, 4'b1110, 1'b0, 1'b1, 1'b1, 1'b0);
    stall = 1'b1;
    tick();
    flush = 1'b1;   // ignored under stall
    tick();
    checks++; if (flags !== 4'b0001) begin errors++; $display("FAIL stall_flags flags=%b exp 0001", flags); end
    checks++; if ({pc_src, reg_write, mem_write, cond_ex} !== 4'b1001) begin errors++; $display("FAIL stall_hold got %b exp 1001", {pc_src, reg_write, mem_write, cond_ex}); end
    checks++; if (exec_cnt !== 4'd13 || skip_cnt !== 4'd7) begin errors++; $display("FAIL stall_cnt got %0d/%0d exp 13/7", exec_cnt, skip_cnt); end
    stall = 1'b0;
    flush = 1'b1;
    tick();
    checks++; if (flags !== 4'b0001) begin errors++; $display("FAIL flush_flags flags=%b exp 0001", flags); end
    checks++; if ({pc_src, reg_write, mem_write, cond_ex} !== 4'b0000) begin errors++; $display("FAIL flush_en got %b exp 0000", {pc_src, reg_write, mem_write, cond_ex}); end
    checks++; if (exec_cnt !== 4'd13 || skip_cnt !== 4'd7) begin errors++; $display("FAIL flush_cnt got %0d/%0d exp 13/7", exec_cnt, skip_cnt); end
    idle();
  endtask

  task automatic test_saturation();
    instr(4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); tick();
    checks++; if (exec_cnt !== 4'd15) begin errors++; $display("FAIL sat_reach got %0d exp 15", exec_cnt); end
    tick(); tick();
    checks++; if (exec_cnt !== 4'd15) begin errors++; $display("FAIL sat_exec got %0d exp 15", exec_cnt); end
    instr(4'b1111, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    checks++; if (skip_cnt !== 4'd15) begin errors++; $display("FAIL sat_skip got %0d exp 15", skip_cnt); end
    // reset wins over stall
    stall = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (exec_cnt !== 4'd0 || skip_cnt !== 4'd0 || flags !== 4'b0000) begin errors++; $display("FAIL reset_over_stall got %0d/%0d flags=%b exp 0/0 0000", exec_cnt, skip_cnt, flags); end
    idle();
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_flag_write();
    test_partial_write();
    test_signed();
    test_back_to_back();
    test_gating();
    test_stall_flush();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Consumer end of the ALU flag interface: latches the 4-bit ALU flag vector into an architectural NZCV flag register.
- Evaluates each instruction's 4-bit condition field against the stored flags.
- Gates that instruction's PC, register-file and memory write enables.
- Sits between the decoder and the datapath write ports; keeps saturating counters of executed and skipped instructions for debug.

Parameters:
- CNT_W, 16, width of the executed and skipped instruction counters (saturating).

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  current decoded instruction is valid this cycle.
- stall  in  1  pipeline stall; freezes all state.
- flush  in  1  cancels the current instruction.
- cond  in  4  instruction condition field.
- alu_flags  in  4  flags from the ALU for the current instruction: [3]=V, [2]=C, [1]=N, [0]=Z.
- flag_w  in  2  flag write request: [1] updates N,Z; [0] updates C,V.
- pc_s  in  1  decoder request to write the PC.
- reg_w  in  1  decoder request to write the register file.
- mem_w  in  1  decoder request to write memory.
- no_write  in  1  compare-type instruction; suppress the register write.
- pc_src  out  1  registered, gated PC write.
- reg_write  out  1  registered, gated register write.
- mem_write  out  1  registered, gated memory write.
- cond_ex  out  1  registered condition-passed indicator.
- flags  out  4  architectural flag register, same bit order as alu_flags.
- exec_cnt  out  CNT_W  number of instructions executed.
- skip_cnt  out  CNT_W  number of instructions skipped.

Behaviour:
- Reset, synchronous and active-high: on a rising edge with reset=1, every output clears to 0: flags, pc_src, reg_write, mem_write, cond_ex, exec_cnt, skip_cnt. Reset overrides stall and flush.
- Accepted instruction: a cycle with instr_valid=1, stall=0, flush=0.
- Condition evaluation (combinational, against the stored flags, not alu_flags), with c = cond:
  - 0000 Z; 0001 ~Z.
  - 0010 C; 0011 ~C.
  - 0100 N; 0101 ~N.
  - 0110 V; 0111 ~V.
  - 1000 C&~Z; 1001 ~C|Z.
  - 1010 N==V; 1011 N!=V.
  - 1100 ~Z&(N==V); 1101 Z|(N!=V).
  - 1110 always true.
  - 1111 reserved: false, and treated as a skipped instruction.
- Flag update on an accepted instruction with pass=1:
  - flag_w[1]: flags[1:0] <= alu_flags[1:0].
  - flag_w[0]: flags[3:2] <= alu_flags[3:2].
  - Unselected halves hold.
  - No update if pass=0.
- Visibility: updated flags are visible to the condition check of the next accepted instruction. Back-to-back flag-setting then conditional instructions need no bubble. An instruction never sees its own alu_flags.
- Output latency: one cycle. On the edge after an accepted instruction:
  - cond_ex <= pass.
  - pc_src <= pass & pc_s.
  - reg_write <= pass & reg_w & ~no_write.
  - mem_write <= pass & mem_w.
- Outputs are single-cycle pulses: on a cycle with instr_valid=0 and stall=0, all four registered enables clear to 0.
- Stall (stall=1, reset=0):
  - all registers hold, including outputs and counters;
  - instr_valid is ignored;
  - flush is ignored (stall has priority over flush).
- Flush (flush=1, stall=0):
  - instruction discarded: no flag update, no counter change;
  - pc_src, reg_write, mem_write, cond_ex <= 0.
- Counters:
  - accepted with pass=1: exec_cnt +1;
  - accepted with pass=0: skip_cnt +1;
  - both saturate at 2^CNT_W-1 and never wrap;
  - cleared only by reset.
- Unknown-free: every output is driven from registers; no combinational path from inputs to outputs.

Test Plan:
- Reset: after reset, flags=0000, all enables 0, counters 0. Instr cond=0000 (EQ), reg_w=1 -> next cycle reg_write=0, cond_ex=0, skip_cnt=1.
- Flag write then use: accepted cond=1110, flag_w=11, alu_flags=0001 -> flags=0001. Next cycle cond=0000, reg_w=1 -> following cycle reg_write=1, exec_cnt=2.
- Partial write: flags=1111, then cond=1110, flag_w=10, alu_flags=0000 -> flags=1100.
- Signed compares: flags N=1, V=0, Z=0 -> cond=1011 passes, cond=1010 skips, cond=1100 skips, cond=1101 passes.
- Gating: cond=1110, pc_s=1, mem_w=1, reg_w=1, no_write=1 -> pc_src=1, mem_write=1, reg_write=0. cond=1111 -> all 0, skip_cnt+1.
- Stall and flush: with stall=1, instr_valid=1, flag_w=11 -> flags, outputs and counters unchanged. flush=1 with cond=1110, flag_w=11 -> flags unchanged, enables 0. Counter preloaded at 2^CNT_W-1 plus a passing instr -> exec_cnt stays at max.
